imem_arbiter: RTL
=================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 32000, meaning instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter AW, default 15, meaning memory word-address width, with 2**AW >= DEPTH.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port f_req  input  1  fetch-side read request.
REQ-006 SHALL have port f_addr  input  32  fetch byte address.
REQ-007 SHALL have port f_flush  input  1  fetch redirect; cancels the fetch response in flight.
REQ-008 SHALL have port f_gnt  output  1  fetch request accepted this cycle.
REQ-009 SHALL have port f_rvalid  output  1  fetch response valid.
REQ-010 SHALL have port f_rdata  output  32  fetch instruction word.
REQ-011 SHALL have port f_err  output  1  fetch response is an error.
REQ-012 SHALL have port l_req  input  1  loader/debug request.
REQ-013 SHALL have port l_we  input  1  loader write enable (1 = write, 0 = read).
REQ-014 SHALL have port l_lock  input  1  loader holds ownership across consecutive cycles.
REQ-015 SHALL have port l_addr  input  32  loader byte address.
REQ-016 SHALL have port l_wdata  input  32  loader write data.
REQ-017 SHALL have port l_gnt  output  1  loader request accepted this cycle.
REQ-018 SHALL have port l_rvalid  output  1  loader response valid (reads and writes).
REQ-019 SHALL have port l_rdata  output  32  loader read data.
REQ-020 SHALL have port l_err  output  1  loader response is an error.
REQ-021 SHALL have port mem_en  output  1  memory access strobe.
REQ-022 SHALL have port mem_we  output  1  memory write strobe.
REQ-023 SHALL have port mem_addr  output  AW  memory word address.
REQ-024 SHALL have port mem_wdata  output  32  memory write data.
REQ-025 SHALL have port mem_rdata  input  32  memory read data, valid one cycle after mem_en with mem_we = 0.

Function
REQ-026 SHALL grant at most one requester per cycle; f_gnt and l_gnt SHALL be combinational from the current requests and state.
REQ-027 SHALL arbitrate round-robin: on contention, grant the requester not granted most recently (register last_gnt).
REQ-028 SHALL implement the FSM states IDLE, FETCH and LOAD_LOCKED; LOAD_LOCKED is entered when the loader is granted with l_lock = 1 and is left when l_req = 0 or l_lock = 0.
REQ-029 SHALL grant the loader on every l_req cycle while in LOAD_LOCKED, with f_gnt = 0.
REQ-030 SHALL drive mem_en = 1, mem_addr = addr[AW+1:2], mem_we = l_we & l_gnt and mem_wdata = l_wdata in the grant cycle.
REQ-031 SHALL treat a request as an error when addr[1:0] != 0 or addr[31:2] >= DEPTH; an error request SHALL be granted, SHALL NOT assert mem_en, and SHALL respond with err = 1 and rdata = 0.
REQ-032 SHALL assert the owner's rvalid exactly one cycle after each grant, with rdata = mem_rdata for reads, rdata = 0 for writes, and err as registered.
REQ-033 SHALL return rvalid, err and rdata to 0 in every cycle without a response.
REQ-034 SHALL suppress the fetch response due next cycle when f_flush = 1 in the grant cycle or in the response cycle; the memory access is still performed.
REQ-035 SHALL grant a fetch request that coincides with f_flush.
REQ-036 SHALL sustain one access per cycle (back-to-back grants) with no idle bubbles.

Reset
REQ-037 SHALL, while rst = 1, force state = IDLE, last_gnt = loader, and all gnt, rvalid, err and mem_en outputs = 0, with f_rdata = l_rdata = 0.
REQ-038 SHALL drop any response in flight when rst asserts mid-access; no rvalid SHALL appear after reset release without a new grant.

Verification
REQ-039 SHALL pass: f_req = 1 at f_addr = 0x10 with mem[4] = 0x00500093 -> f_gnt in cycle N, mem_addr = 4, f_rvalid with f_rdata = 0x00500093 in cycle N+1.
REQ-040 SHALL pass: f_req and l_req held together for 4 cycles from reset -> grants alternate F, L, F, L.
REQ-041 SHALL pass: loader write l_addr = 0x20, l_wdata = 0xDEADBEEF, then fetch at 0x20 -> f_rdata = 0xDEADBEEF.
REQ-042 SHALL pass: l_lock = 1 with 3 loader writes while f_req = 1 -> f_gnt = 0 for 3 cycles, fetch granted in the 4th cycle.
REQ-043 SHALL pass: f_addr = 0x6 and f_addr = 4*DEPTH -> mem_en = 0, f_err = 1, f_rdata = 0 in cycle N+1.
REQ-044 SHALL pass: f_flush = 1 in the cycle after a fetch grant -> f_rvalid = 0 in that cycle; rst asserted mid-access -> no rvalid after release.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter: two-port arbiter in front of a single-port instruction memory.
// The fetch port (f_*) and the loader/debug port (l_*) share one access per
// cycle. Arbitration is round-robin on contention; the loader can hold
// ownership with l_lock. Every grant receives a response exactly one cycle
// later. Misaligned or out-of-range addresses are granted but answered with
// err = 1 and never reach the memory.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   f_req/f_addr/f_flush             fetch request, byte address, redirect
//   f_gnt/f_rvalid/f_rdata/f_err     fetch grant and response
//   l_req/l_we/l_lock/l_addr/l_wdata loader request, write, lock, address, data
//   l_gnt/l_rvalid/l_rdata/l_err     loader grant and response
//   mem_en/mem_we/mem_addr/mem_wdata memory strobe, write, word address, data
//   mem_rdata                        memory read data (one cycle after mem_en)
module imem_arbiter #(
    parameter int unsigned DEPTH = 32000,
    parameter int unsigned AW    = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [31:0]   f_addr,
    input  logic          f_flush,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [31:0]   f_rdata,
    output logic          f_err,
    input  logic          l_req,
    input  logic          l_we,
    input  logic          l_lock,
    input  logic [31:0]   l_addr,
    input  logic [31:0]   l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [31:0]   l_rdata,
    output logic          l_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int unsigned WORD_AW = 30;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        FETCH       = 2'd1,
        LOAD_LOCKED = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        last_l_q, last_l_d;    // 1 = loader was granted most recently
    logic        f_pend_q, f_pend_d;
    logic        f_perr_q, f_perr_d;
    logic        l_pend_q, l_pend_d;
    logic        l_perr_q, l_perr_d;
    logic        l_pwr_q,  l_pwr_d;

    logic [31:0] sel_addr;
    logic        sel_err;
    logic        gnt_any;

    // Grant, next state, memory strobes and response bookkeeping
    always_comb begin
        state_d  = state_q;
        last_l_d = last_l_q;
        f_gnt    = 1'b0;
        l_gnt    = 1'b0;

        if (!rst) begin
            if (state_q == LOAD_LOCKED && l_req) begin
                l_gnt = 1'b1;
            end else if (f_req && l_req) begin
                if (last_l_q) f_gnt = 1'b1;
                else          l_gnt = 1'b1;
            end else begin
                f_gnt = f_req;
                l_gnt = l_req;
            end
        end

        if (l_gnt && l_lock) state_d = LOAD_LOCKED;
        else if (f_gnt)      state_d = FETCH;
        else                 state_d = IDLE;

        if (f_gnt) last_l_d = 1'b0;
        if (l_gnt) last_l_d = 1'b1;

        gnt_any  = f_gnt | l_gnt;
        sel_addr = l_gnt ? l_addr : f_addr;
        sel_err  = (sel_addr[1:0] != 2'b00) ||
                   (sel_addr[31:2] >= WORD_AW'(DEPTH));

        mem_en    = gnt_any & ~sel_err;
        mem_we    = l_gnt & l_we & ~sel_err;
        mem_addr  = gnt_any ? sel_addr[AW+1:2] : AW'(0);
        mem_wdata = l_wdata;

        // A flush in the grant cycle cancels the response before it is due
        f_pend_d = f_gnt & ~f_flush;
        f_perr_d = f_gnt & sel_err;
        l_pend_d = l_gnt;
        l_perr_d = l_gnt & sel_err;
        l_pwr_d  = l_gnt & l_we;
    end

    // State and response registers; reset drops any response in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_l_q <= 1'b1;
            f_pend_q <= 1'b0;
            f_perr_q <= 1'b0;
            l_pend_q <= 1'b0;
            l_perr_q <= 1'b0;
            l_pwr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_l_q <= last_l_d;
            f_pend_q <= f_pend_d;
            f_perr_q <= f_perr_d;
            l_pend_q <= l_pend_d;
            l_perr_q <= l_perr_d;
            l_pwr_q  <= l_pwr_d;
        end
    end

    // Responses; a flush in the response cycle also hides the fetch reply
    always_comb begin
        f_rvalid = f_pend_q & ~f_flush;
        f_err    = f_rvalid & f_perr_q;
        f_rdata  = (f_rvalid && !f_perr_q) ? mem_rdata : 32'd0;
        l_rvalid = l_pend_q;
        l_err    = l_pend_q & l_perr_q;
        l_rdata  = (l_pend_q && !l_perr_q && !l_pwr_q) ? mem_rdata : 32'd0;
    end

endmodule
